// File: rtl/arb_requester.sv
// arb_requester: requester-side agent for one port of a 3-way fixed-priority
// grant arbiter. It accepts a job of N beats, holds req until the last beat has
// been granted, and counts preemptions (XFER->HOLD) in a saturating counter.
// Optional feature macro: ARB_REQ_TIMEOUT_EN. It abandons a job after WAIT_MAX
// consecutive ungranted REQ/HOLD cycles.
module arb_requester #(
  parameter int LEN_W    = 4,
  parameter int WAIT_MAX = 16,
  parameter int PCNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  input  logic [LEN_W-1:0]  job_len,
  output logic              job_ready,
  output logic              req,
  input  logic              gnt,
  output logic              beat,
  output logic              done,
  output logic              timeout,
  output logic [PCNT_W-1:0] preempt_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_HOLD,
    S_DONE
`ifdef ARB_REQ_TIMEOUT_EN
    , S_TOUT
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  logic [WAIT_W-1:0]  wait_q, wait_d;
`endif

  // Decoded outputs: req is only visible in the three requesting states.
  assign job_ready   = (state_q == S_IDLE);
  assign req         = (state_q == S_REQ) || (state_q == S_XFER) || (state_q == S_HOLD);
  assign beat        = req & gnt;
  assign done        = (state_q == S_DONE);
  assign preempt_cnt = pcnt_q;
`ifdef ARB_REQ_TIMEOUT_EN
  assign timeout     = (state_q == S_TOUT);
`else
  assign timeout     = 1'b0;
`endif

  // Next-state logic: job acceptance, beat consumption, preemption and timeout.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pcnt_d  = pcnt_q;
`ifdef ARB_REQ_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          rem_d   = job_len;
          state_d = (job_len == '0) ? S_DONE : S_REQ;
`ifdef ARB_REQ_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      S_REQ, S_HOLD: begin
        if (gnt) begin
          rem_d   = (rem_q != '0) ? rem_q - LEN_W'(1) : '0;
          state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_XFER;
`ifdef ARB_REQ_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
`ifdef ARB_REQ_TIMEOUT_EN
        // A beat in the same cycle wins over the timeout.
        else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
          state_d = S_TOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      S_XFER: begin
        if (gnt) begin
          rem_d   = (rem_q != '0) ? rem_q - LEN_W'(1) : '0;
          state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_XFER;
`ifdef ARB_REQ_TIMEOUT_EN
          wait_d  = '0;
`endif
        end else begin
          state_d = S_HOLD;
          if (pcnt_q != '1) pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
`ifdef ARB_REQ_TIMEOUT_EN
      S_TOUT: begin
        state_d = S_IDLE;
        rem_d   = '0;
        wait_d  = '0;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; a reset drops the job.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      pcnt_q  <= '0;
`ifdef ARB_REQ_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pcnt_q  <= pcnt_d;
`ifdef ARB_REQ_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: job-level reference model plus directed scenarios.
module tb_arb_requester;

  localparam int LEN_W    = 4;
  localparam int WAIT_MAX = 16;
  localparam int PCNT_W   = 8;
  localparam int PCNT_MAX = (1 << PCNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              job_valid;
  logic [LEN_W-1:0]  job_len;
  logic              job_ready;
  logic              req;
  logic              gnt;
  logic              beat;
  logic              done;
  logic              timeout;
  logic [PCNT_W-1:0] preempt_cnt;

  int tests = 0;
  int fails = 0;
  logic cmp_en = 1'b0;

  arb_requester #(.LEN_W(LEN_W), .WAIT_MAX(WAIT_MAX), .PCNT_W(PCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_len(job_len),
    .job_ready(job_ready), .req(req), .gnt(gnt), .beat(beat), .done(done),
    .timeout(timeout), .preempt_cnt(preempt_cnt)
  );

  always #5 clk = ~clk;

  // Job-level model: a job is either active (beats outstanding) or finished
  // with a one-cycle completion/abandon pulse; preemption is a gap directly
  // after a granted beat.
  bit m_active    = 1'b0;
  int m_rem       = 0;
  bit m_prev_beat = 1'b0;
  int m_pulse     = 0;   // 0 none, 1 done, 2 timeout
  int m_waits     = 0;
  int m_pcnt      = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model mid-cycle, then advance the model with the
  // inputs that the coming rising edge will see.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_req",       int'(req),         int'(m_active));
      chk("m_beat",      int'(beat),        int'(m_active && gnt));
      chk("m_done",      int'(done),        int'(m_pulse == 1));
      chk("m_timeout",   int'(timeout),     int'(m_pulse == 2));
      chk("m_job_ready", int'(job_ready),   int'(!m_active && m_pulse == 0));
      chk("m_pcnt",      int'(preempt_cnt), m_pcnt);
    end
    if (!rst_n) begin
      m_active = 0; m_rem = 0; m_prev_beat = 0; m_pulse = 0; m_waits = 0; m_pcnt = 0;
    end else if (m_pulse != 0) begin
      m_pulse = 0;
    end else if (!m_active) begin
      if (job_valid) begin
        if (job_len == 0) m_pulse = 1;
        else begin
          m_active = 1; m_rem = int'(job_len); m_prev_beat = 0; m_waits = 0;
        end
      end
    end else if (gnt) begin
      m_rem--; m_waits = 0; m_prev_beat = 1;
      if (m_rem == 0) begin m_active = 0; m_pulse = 1; end
    end else if (m_prev_beat) begin
      m_prev_beat = 0;
      if (m_pcnt < PCNT_MAX) m_pcnt++;
    end else begin
`ifdef ARB_REQ_TIMEOUT_EN
      if (m_waits == WAIT_MAX - 1) begin
        m_active = 0; m_pulse = 2; m_rem = 0; m_waits = 0;
      end else m_waits++;
`endif
    end
  end

  // One clock cycle: inputs applied just after the rising edge, returns at the
  // falling edge so the caller can inspect that cycle's outputs.
  task automatic cyc(input logic g, input logic jv, input int l, input logic rn);
    @(posedge clk); #1;
    gnt = g; job_valid = jv; job_len = LEN_W'(l); rst_n = rn;
    @(negedge clk);
  endtask

  int rc, bc, dc, rdy, tc, drop;
  logic gpat [6];

  initial begin
    rst_n = 1'b0; gnt = 1'b1; job_valid = 1'b0; job_len = '0;

    // Reset with gnt held high.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cmp_en = 1'b1;
    chk("rst_req", int'(req), 0);
    chk("rst_beat", int'(beat), 0);
    chk("rst_job_ready", int'(job_ready), 1);
    chk("rst_pcnt", int'(preempt_cnt), 0);

    // len=3 with constant grant.
    cyc(1, 1, 3, 1);
    rc = 0; bc = 0; dc = 0; rdy = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 0, 1);
      if (req) rc++;
      if (beat) bc++;
      if (done && dc == 0) dc = i;
      if (job_ready && rdy == 0) rdy = i;
    end
    chk("t2_req_cycles", rc, 3);
    chk("t2_beats", bc, 3);
    chk("t2_done_cycle", dc, 4);
    chk("t2_ready_cycle", rdy, 5);

    // len=4 with grant 1,0,0,1,1,1: one preemption, req held through it.
    gpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    cyc(1, 1, 4, 1);
    bc = 0; dc = 0; drop = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc((i <= 6) ? gpat[i-1] : 1'b1, 0, 0, 1);
      if (beat) bc++;
      if (done && dc == 0) dc = i;
      if (dc == 0 && !req) drop = 1;
    end
    chk("t3_pcnt", int'(preempt_cnt), 1);
    chk("t3_beats", bc, 4);
    chk("t3_done_cycle", dc, 7);
    chk("t3_req_drop", drop, 0);

    // Zero-length job completes immediately without a request.
    cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 1);
    chk("t4_done", int'(done), 1);
    chk("t4_req", int'(req), 0);
    cyc(1, 0, 0, 1);
    chk("t4_done_gone", int'(done), 0);
    chk("t4_ready", int'(job_ready), 1);

    // Grant never comes.
    cyc(0, 1, 15, 1);
    tc = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc(0, 0, 0, 1);
      if (timeout && tc == 0) begin
        tc = i;
        chk("t5_req_at_tout", int'(req), 0);
      end
    end
`ifdef ARB_REQ_TIMEOUT_EN
    chk("t5_tout_cycle", tc, 17);
    chk("t5_idle_after", int'(job_ready), 1);
`else
    chk("t5_no_tout", tc, 0);
    chk("t5_req_c100", int'(req), 1);
`endif

    // Reset lands on beat 2 of a len=5 job.
    cyc(0, 0, 0, 0);
    cyc(1, 1, 5, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    chk("t6_beat2", int'(beat), 1);
    dc = 0; rc = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1);
      if (done) dc++;
      if (req) rc++;
    end
    chk("t6_no_done", dc, 0);
    chk("t6_req_low", rc, 0);
    chk("t6_pcnt", int'(preempt_cnt), 0);
    // Nothing left over: a fresh len=2 job takes exactly 2 beats.
    cyc(1, 1, 2, 1);
    bc = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 1);
      if (beat) bc++;
    end
    chk("t6_next_beats", bc, 2);

    // Alternating grant over many len=15 jobs saturates preempt_cnt.
    for (int i = 0; i < 1500; i++) cyc(logic'(i[0]), 1, 15, 1);
    cyc(0, 0, 0, 1);
    chk("pcnt_sat", int'(preempt_cnt), PCNT_MAX);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
